// File: rtl/v2f_arb_pkg.sv
// Shared types and constants for the v2f ALU arbiter: opcodes, datapath widths
// and the ALU pipeline entry that travels from issue to the response FIFO.
package v2f_arb_pkg;

  localparam int unsigned OP_W     = 4;
  localparam int unsigned DATA_W   = 32;
  // Largest requester index width (N_REQ <= 16); narrower configs truncate.
  localparam int unsigned ID_MAX_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV = 4'd3;
  localparam logic [OP_W-1:0] OP_MOD = 4'd4;
  localparam logic [OP_W-1:0] OP_AND = 4'd5;
  localparam logic [OP_W-1:0] OP_OR  = 4'd6;
  localparam logic [OP_W-1:0] OP_XOR = 4'd7;
  localparam logic [OP_W-1:0] OP_SHL = 4'd8;
  localparam logic [OP_W-1:0] OP_SHR = 4'd9;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [DATA_W-1:0]   y;
    logic                err;
  } pipe_ent_t;

endpackage

// File: rtl/v2f_arb_alu.sv
// Shared 32-bit ALU: combinational decode/compute followed by LATENCY-1
// retiming registers. Never stalls; the top guarantees downstream space.
module v2f_arb_alu
  import v2f_arb_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [ID_MAX_W-1:0] i_id,
  input  logic [OP_W-1:0]     i_op,
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  output pipe_ent_t           o_ent
);

  localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] NEG_ONE = '1;

  logic              w_b_zero;
  logic              w_ovf;
  logic [DATA_W-1:0] w_div_b;
  logic [DATA_W-1:0] w_quot;
  logic [DATA_W-1:0] w_rem;
  logic [4:0]        w_sh;
  pipe_ent_t         w_comp;

  // Divider sees a safe divisor so the zero and INT_MIN/-1 cases never reach it.
  assign w_b_zero = (i_b == '0);
  assign w_ovf    = (i_a == INT_MIN) && (i_b == NEG_ONE);
  assign w_div_b  = (w_b_zero || w_ovf) ? DATA_W'(1) : i_b;
  assign w_quot   = DATA_W'($signed(i_a) / $signed(w_div_b));
  assign w_rem    = DATA_W'($signed(i_a) % $signed(w_div_b));
  assign w_sh     = i_b[4:0];

  always_comb begin
    w_comp       = '0;
    w_comp.valid = i_valid;
    w_comp.id    = i_id;
    case (i_op)
      OP_ADD: w_comp.y = i_a + i_b;
      OP_SUB: w_comp.y = i_a - i_b;
      OP_MUL: w_comp.y = i_a * i_b;
      OP_DIV: begin
        if (w_b_zero)  w_comp.err = 1'b1;
        else if (w_ovf) w_comp.y  = INT_MIN;
        else            w_comp.y  = w_quot;
      end
      OP_MOD: begin
        if (w_b_zero)   w_comp.err = 1'b1;
        else if (!w_ovf) w_comp.y  = w_rem;
      end
      OP_AND: w_comp.y = i_a & i_b;
      OP_OR:  w_comp.y = i_a | i_b;
      OP_XOR: w_comp.y = i_a ^ i_b;
      OP_SHL: w_comp.y = i_a << w_sh;
      OP_SHR: w_comp.y = DATA_W'($signed(i_a) >>> w_sh);
      default: w_comp.err = 1'b1;
    endcase
  end

  generate
    if (LATENCY == 1) begin : g_comb
      assign o_ent = w_comp;
    end else begin : g_pipe
      localparam int unsigned N_STG = LATENCY - 1;
      pipe_ent_t r_stage [N_STG];

      // Retiming chain; reset drops every in-flight operation.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < N_STG; i++) r_stage[i] <= '0;
        end else begin
          r_stage[0] <= w_comp;
          for (int unsigned i = 1; i < N_STG; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_ent = r_stage[N_STG-1];
    end
  endgenerate

endmodule

// File: rtl/v2f_alu_arbiter.sv
// Round-robin arbiter sharing one pipelined ALU between N_REQ requesters, with
// credit-protected in-order response FIFO. Define V2F_ALU_ARB_ERR_EN for rsp_err.
module v2f_alu_arbiter
  import v2f_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*OP_W-1:0]     req_op,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(N_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]         rsp_y
`ifdef V2F_ALU_ARB_ERR_EN
  ,
  output logic                      rsp_err
`endif
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ID_W-1:0]   r_rr;
  logic [CNT_W-1:0]  r_cred;
  logic              w_issue;
  logic [ID_W-1:0]   w_gnt_id;
  logic [ID_W:0]     w_idx;
  logic [OP_W-1:0]   w_op;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  pipe_ent_t         w_alu_out;
  logic              w_push;
  logic              w_pop;
  logic              w_unused;

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_mem_id [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_y  [FIFO_DEPTH];
`ifdef V2F_ALU_ARB_ERR_EN
  logic              r_mem_err [FIFO_DEPTH];
`endif

  // Round-robin search from r_rr; only eligible while a credit is available.
  always_comb begin
    req_ready = '0;
    w_issue   = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    if (!rst && (r_cred != '0)) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        w_idx = (ID_W+1)'(r_rr) + (ID_W+1)'(k);
        if (w_idx >= (ID_W+1)'(N_REQ)) w_idx = w_idx - (ID_W+1)'(N_REQ);
        if (!w_issue && req_valid[w_idx[ID_W-1:0]]) begin
          w_issue  = 1'b1;
          w_gnt_id = w_idx[ID_W-1:0];
        end
      end
    end
    if (w_issue) req_ready[w_gnt_id] = 1'b1;
  end

  always_comb begin
    w_op = '0;
    w_a  = '0;
    w_b  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        w_op = req_op[i*OP_W +: OP_W];
        w_a  = req_a[i*DATA_W +: DATA_W];
        w_b  = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= '0;
    end else if (w_issue) begin
      r_rr <= (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
    end
  end

  // Credits cover FIFO entries plus operations still inside the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cred <= CNT_W'(FIFO_DEPTH);
    end else if (w_issue && !w_pop) begin
      r_cred <= r_cred - CNT_W'(1);
    end else if (!w_issue && w_pop) begin
      r_cred <= r_cred + CNT_W'(1);
    end
  end

  v2f_arb_alu #(
    .LATENCY (LATENCY)
  ) u_alu (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_issue),
    .i_id    (ID_MAX_W'(w_gnt_id)),
    .i_op    (w_op),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_ent   (w_alu_out)
  );

  assign w_push   = w_alu_out.valid;
  assign w_pop    = r_rsp_valid && rsp_ready;
  assign w_unused = ^{w_alu_out.id, w_alu_out.err};

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CNT_W'(1);
  end

  // Response FIFO; head is read straight from storage, no fall-through path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rsp_valid <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_id[i] <= '0;
        r_mem_y[i]  <= '0;
`ifdef V2F_ALU_ARB_ERR_EN
        r_mem_err[i] <= 1'b0;
`endif
      end
    end else begin
      if (w_push) begin
        r_mem_id[r_wr_ptr] <= w_alu_out.id[ID_W-1:0];
        r_mem_y[r_wr_ptr]  <= w_alu_out.y;
`ifdef V2F_ALU_ARB_ERR_EN
        r_mem_err[r_wr_ptr] <= w_alu_out.err;
`endif
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_nxt;
      r_rsp_valid <= (w_count_nxt != '0);
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_mem_id[r_rd_ptr];
  assign rsp_y     = r_mem_y[r_rd_ptr];
`ifdef V2F_ALU_ARB_ERR_EN
  assign rsp_err   = r_mem_err[r_rd_ptr];
`endif

endmodule
